// File: rtl/noc_dram_client_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : noc_dram_client_pkg                                           |
// | Description : Shared NoC definitions: flit widths, header flit layout,      |
// |               message type codes and the flit-count helper.                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package noc_dram_client_pkg;

   localparam int NOC_DATA_WIDTH      = 512;
   localparam int NOC_DATA_BYTES      = NOC_DATA_WIDTH / 8;
   localparam int NOC_DATA_BYTES_W    = $clog2(NOC_DATA_BYTES);
   localparam int MSG_ADDR_WIDTH      = 40;
   localparam int MSG_DATA_SIZE_WIDTH = 13;
   localparam int MSG_LENGTH_WIDTH    = 8;
   localparam int MSG_TYPE_WIDTH      = 8;
   localparam int CHIP_ID_WIDTH       = 14;
   localparam int XY_WIDTH            = 8;

   localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM      = 8'd19;
   localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM     = 8'd20;
   localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM_ACK  = 8'd24;
   localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM_ACK = 8'd25;

   // Bit positions of the two header fields the response decoder needs.
   localparam int HDR_MSG_TYPE_LSB = MSG_ADDR_WIDTH + MSG_DATA_SIZE_WIDTH;
   localparam int HDR_MSG_LEN_LSB  = HDR_MSG_TYPE_LSB + MSG_TYPE_WIDTH;
   localparam int HDR_USED_W       = 2*CHIP_ID_WIDTH + 4*XY_WIDTH + MSG_LENGTH_WIDTH
                                     + MSG_TYPE_WIDTH + MSG_DATA_SIZE_WIDTH + MSG_ADDR_WIDTH;

   typedef struct packed {
      logic [NOC_DATA_WIDTH-HDR_USED_W-1:0] rsvd;
      logic [CHIP_ID_WIDTH-1:0]             dst_chip_id;
      logic [XY_WIDTH-1:0]                  dst_x_coord;
      logic [XY_WIDTH-1:0]                  dst_y_coord;
      logic [CHIP_ID_WIDTH-1:0]             src_chip_id;
      logic [XY_WIDTH-1:0]                  src_x_coord;
      logic [XY_WIDTH-1:0]                  src_y_coord;
      logic [MSG_LENGTH_WIDTH-1:0]          msg_len;
      logic [MSG_TYPE_WIDTH-1:0]            msg_type;
      logic [MSG_DATA_SIZE_WIDTH-1:0]       data_size;
      logic [MSG_ADDR_WIDTH-1:0]            addr;
   } noc_hdr_flit;

   // Number of payload flits for a byte count, rounded up (shift-and-add only).
   function automatic logic [MSG_LENGTH_WIDTH-1:0] ceil_flits(
      input logic [MSG_DATA_SIZE_WIDTH-1:0] size
   );
      return MSG_LENGTH_WIDTH'(size >> NOC_DATA_BYTES_W)
           + MSG_LENGTH_WIDTH'(|size[NOC_DATA_BYTES_W-1:0]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/noc_dram_hdr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : noc_dram_hdr_gen                                              |
// | Description : Combinational packing of the outbound STORE_MEM / LOAD_MEM    |
// |               header flit from the registered request.                     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module noc_dram_hdr_gen
   import noc_dram_client_pkg::*;
#(
   parameter logic [XY_WIDTH-1:0] SRC_X  = '0,
   parameter logic [XY_WIDTH-1:0] SRC_Y  = '0,
   parameter logic [XY_WIDTH-1:0] DRAM_X = '0,
   parameter logic [XY_WIDTH-1:0] DRAM_Y = '0
)(
   input  logic                           i_wr,
   input  logic [MSG_ADDR_WIDTH-1:0]      i_addr,
   input  logic [MSG_DATA_SIZE_WIDTH-1:0] i_size,
   input  logic [MSG_LENGTH_WIDTH-1:0]    i_flits,
   output logic [NOC_DATA_WIDTH-1:0]      o_hdr
);

   noc_hdr_flit w_hdr;

   // Build the header; unused fields (chip ids, reserved bits) stay zero.
   always_comb begin
      w_hdr             = '0;
      w_hdr.dst_x_coord = DRAM_X;
      w_hdr.dst_y_coord = DRAM_Y;
      w_hdr.src_x_coord = SRC_X;
      w_hdr.src_y_coord = SRC_Y;
      w_hdr.addr        = i_addr;
      w_hdr.data_size   = i_size;
      w_hdr.msg_type    = i_wr ? MSG_TYPE_STORE_MEM : MSG_TYPE_LOAD_MEM;
      // Loads carry no payload, so their header length is zero.
      w_hdr.msg_len     = i_wr ? i_flits : '0;
   end

   assign o_hdr = w_hdr;

endmodule
`default_nettype wire

// File: rtl/noc_dram_client.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : noc_dram_client                                               |
// | Description : Single-outstanding NoC0 requester for the DRAM controller.    |
// |               Turns load/store commands into LOAD_MEM / STORE_MEM messages  |
// |               and returns read data or a write-done handshake.              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module noc_dram_client
   import noc_dram_client_pkg::*;
#(
   parameter logic [XY_WIDTH-1:0] SRC_X  = '0,
   parameter logic [XY_WIDTH-1:0] SRC_Y  = '0,
   parameter logic [XY_WIDTH-1:0] DRAM_X = '0,
   parameter logic [XY_WIDTH-1:0] DRAM_Y = '0
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_req_val,
   input  logic                           i_req_wr,
   input  logic [MSG_ADDR_WIDTH-1:0]      i_req_addr,
   input  logic [MSG_DATA_SIZE_WIDTH-1:0] i_req_size,
   output logic                           o_req_rdy,
   input  logic                           i_wr_data_val,
   input  logic [NOC_DATA_WIDTH-1:0]      i_wr_data,
   output logic                           o_wr_data_rdy,
   output logic                           o_rd_data_val,
   output logic [NOC_DATA_WIDTH-1:0]      o_rd_data,
   output logic                           o_rd_data_last,
   input  logic                           i_rd_data_rdy,
   output logic                           o_wr_done_val,
   input  logic                           i_wr_done_rdy,
   output logic                           o_resp_err,
   output logic                           o_client_noc0_val,
   output logic [NOC_DATA_WIDTH-1:0]      o_client_noc0_data,
   input  logic                           i_noc0_client_rdy,
   input  logic                           i_noc0_client_val,
   input  logic [NOC_DATA_WIDTH-1:0]      i_noc0_client_data,
   output logic                           o_client_noc0_rdy
);

   localparam logic [MSG_LENGTH_WIDTH-1:0] LEN_ONE = MSG_LENGTH_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_REQ_HDR    = 3'd1,
      S_WR_PAYLOAD = 3'd2,
      S_RESP_HDR   = 3'd3,
      S_RD_PAYLOAD = 3'd4,
      S_WR_DONE    = 3'd5
   } state_t;

   state_t                           r_state;
   state_t                           w_state_nxt;
   logic                             r_wr;
   logic [MSG_ADDR_WIDTH-1:0]        r_addr;
   logic [MSG_DATA_SIZE_WIDTH-1:0]   r_size;
   logic [MSG_LENGTH_WIDTH-1:0]      r_flits;
   logic [MSG_LENGTH_WIDTH-1:0]      r_flit_cnt;
   logic [MSG_LENGTH_WIDTH-1:0]      r_rsp_len;
   logic                             r_resp_err;

   logic                             w_req_acc;
   logic                             w_cnt_clr;
   logic                             w_cnt_inc;
   logic                             w_rsp_latch;
   logic                             w_err_set;
   logic                             w_rd_last;
   logic [NOC_DATA_WIDTH-1:0]        w_hdr;
   logic [MSG_TYPE_WIDTH-1:0]        w_rsp_type;
   logic [MSG_LENGTH_WIDTH-1:0]      w_rsp_len;
   logic [MSG_TYPE_WIDTH-1:0]        w_exp_ack;

   assign w_rsp_type = i_noc0_client_data[HDR_MSG_TYPE_LSB +: MSG_TYPE_WIDTH];
   assign w_rsp_len  = i_noc0_client_data[HDR_MSG_LEN_LSB  +: MSG_LENGTH_WIDTH];
   assign w_exp_ack  = r_wr ? MSG_TYPE_STORE_MEM_ACK : MSG_TYPE_LOAD_MEM_ACK;
   assign w_rd_last  = (r_flit_cnt == (r_rsp_len - LEN_ONE));
   assign o_resp_err = r_resp_err;

   noc_dram_hdr_gen #(
      .SRC_X  (SRC_X),
      .SRC_Y  (SRC_Y),
      .DRAM_X (DRAM_X),
      .DRAM_Y (DRAM_Y)
   ) u_hdr_gen (
      .i_wr    (r_wr),
      .i_addr  (r_addr),
      .i_size  (r_size),
      .i_flits (r_flits),
      .o_hdr   (w_hdr)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Request capture, flit counter, response length and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr       <= 1'b0;
         r_addr     <= '0;
         r_size     <= '0;
         r_flits    <= '0;
         r_flit_cnt <= '0;
         r_rsp_len  <= '0;
         r_resp_err <= 1'b0;
      end else begin
         if (w_req_acc) begin
            r_wr    <= i_req_wr;
            r_addr  <= i_req_addr;
            r_size  <= i_req_size;
            r_flits <= ceil_flits(i_req_size);
         end
         if (w_cnt_clr)      r_flit_cnt <= '0;
         else if (w_cnt_inc) r_flit_cnt <= r_flit_cnt + LEN_ONE;
         if (w_rsp_latch)    r_rsp_len  <= w_rsp_len;
         if (w_err_set)      r_resp_err <= 1'b1;
      end
   end

   // Next-state decode and all handshake / pass-through outputs.
   always_comb begin
      w_state_nxt        = r_state;
      w_req_acc          = 1'b0;
      w_cnt_clr          = 1'b0;
      w_cnt_inc          = 1'b0;
      w_rsp_latch        = 1'b0;
      w_err_set          = 1'b0;
      o_req_rdy          = 1'b0;
      o_wr_data_rdy      = 1'b0;
      o_rd_data_val      = 1'b0;
      o_rd_data          = '0;
      o_rd_data_last     = 1'b0;
      o_wr_done_val      = 1'b0;
      o_client_noc0_val  = 1'b0;
      o_client_noc0_data = '0;
      o_client_noc0_rdy  = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_rdy = 1'b1;
            if (i_req_val) begin
               w_req_acc = 1'b1;
               // Zero-byte requests complete locally without touching the NoC.
               if (i_req_size == '0) w_state_nxt = i_req_wr ? S_WR_DONE : S_IDLE;
               else                  w_state_nxt = S_REQ_HDR;
            end
         end
         S_REQ_HDR: begin
            o_client_noc0_val  = 1'b1;
            o_client_noc0_data = w_hdr;
            if (i_noc0_client_rdy) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = r_wr ? S_WR_PAYLOAD : S_RESP_HDR;
            end
         end
         S_WR_PAYLOAD: begin
            o_client_noc0_val  = i_wr_data_val;
            o_client_noc0_data = i_wr_data;
            o_wr_data_rdy      = i_noc0_client_rdy;
            if (i_wr_data_val && i_noc0_client_rdy) begin
               w_cnt_inc = 1'b1;
               if (r_flit_cnt == (r_flits - LEN_ONE)) w_state_nxt = S_RESP_HDR;
            end
         end
         S_RESP_HDR: begin
            o_client_noc0_rdy = 1'b1;
            if (i_noc0_client_val) begin
               if (w_rsp_type != w_exp_ack) begin
                  // Unexpected response: flag it and keep waiting for the real ACK.
                  w_err_set = 1'b1;
               end else if (r_wr) begin
                  w_state_nxt = S_WR_DONE;
               end else begin
                  w_rsp_latch = 1'b1;
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = (w_rsp_len == '0) ? S_IDLE : S_RD_PAYLOAD;
               end
            end
         end
         S_RD_PAYLOAD: begin
            o_rd_data_val     = i_noc0_client_val;
            o_rd_data         = i_noc0_client_data;
            o_rd_data_last    = w_rd_last;
            o_client_noc0_rdy = i_rd_data_rdy;
            if (i_noc0_client_val && i_rd_data_rdy) begin
               w_cnt_inc = 1'b1;
               if (w_rd_last) w_state_nxt = S_IDLE;
            end
         end
         S_WR_DONE: begin
            o_wr_done_val = 1'b1;
            if (i_wr_done_rdy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/noc_dram_client.md
# noc_dram_client

Upstream requester for the NoC DRAM controller tile. Converts a simple command/data-stream interface from a local engine into NoC0 `MSG_TYPE_STORE_MEM` and `MSG_TYPE_LOAD_MEM` messages, and returns the matching `*_ACK` responses as a read-data stream or a write-done handshake. It allows one outstanding transaction at a time.

## Interface
- `SRC_X`, 0: this tile's x coordinate; written into `src_x_coord`.
- `SRC_Y`, 0: this tile's y coordinate; written into `src_y_coord`.
- `DRAM_X`, 0: DRAM controller x coordinate; written into `dst_x_coord`.
- `DRAM_Y`, 0: DRAM controller y coordinate; written into `dst_y_coord`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_val` in 1: command valid.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in `MSG_ADDR_WIDTH`: byte address.
- `req_size` in `MSG_DATA_SIZE_WIDTH`: transfer size in bytes.
- `req_rdy` out 1: command accept.
- `wr_data_val` in 1, `wr_data` in `NOC_DATA_WIDTH`, `wr_data_rdy` out 1: store payload stream.
- `rd_data_val` out 1, `rd_data` out `NOC_DATA_WIDTH`, `rd_data_last` out 1, `rd_data_rdy` in 1: load data stream.
- `wr_done_val` out 1, `wr_done_rdy` in 1: store completion.
- `resp_err` out 1: sticky flag for an unexpected response type.
- `client_noc0_val` out 1, `client_noc0_data` out `NOC_DATA_WIDTH`, `noc0_client_rdy` in 1: request flits out.
- `noc0_client_val` in 1, `noc0_client_data` in `NOC_DATA_WIDTH`, `client_noc0_rdy` out 1: response flits in.

## Operation
- States: `IDLE`, `REQ_HDR`, `WR_PAYLOAD`, `RESP_HDR`, `RD_PAYLOAD`, `WR_DONE`.
- `IDLE`
  - `req_rdy`=1.
  - On `req_val`, register `req_wr`, `req_addr` and `req_size`, and compute `flits = ceil(req_size / NOC_DATA_BYTES)`.
  - Shift-and-add only: `req_size >> NOC_DATA_BYTES_W`, plus 1 if the low `NOC_DATA_BYTES_W` bits are nonzero.
  - If `req_size`==0: a store goes to `WR_DONE` and a load returns to `IDLE`. No NoC traffic and no `rd_data` in either case.
  - Otherwise go to `REQ_HDR`.
- `REQ_HDR`
  - Drive the header flit, all other fields zero:
    - `dst_chip_id`=0, `dst_x_coord`=`DRAM_X`, `dst_y_coord`=`DRAM_Y`.
    - `src_chip_id`=0, `src_x_coord`=`SRC_X`, `src_y_coord`=`SRC_Y`.
    - `addr`=`req_addr`, `data_size`=`req_size`.
    - `msg_type`=STORE_MEM or LOAD_MEM.
    - `msg_len`=`flits` for a store, 0 for a load.
  - On `noc0_client_rdy`: a store goes to `WR_PAYLOAD` with `flit_cnt`=0; a load goes to `RESP_HDR`.
- `WR_PAYLOAD`
  - Pass-through, no buffering: `client_noc0_val`=`wr_data_val`, `client_noc0_data`=`wr_data`, `wr_data_rdy`=`noc0_client_rdy`.
  - Each transfer increments `flit_cnt`.
  - The transfer with `flit_cnt`==`flits`-1 moves the state to `RESP_HDR`.
- `RESP_HDR`
  - `client_noc0_rdy`=1.
  - On `noc0_client_val`, check `msg_type` against the expected ACK:
    - Mismatch: set `resp_err`, drop the flit, stay in `RESP_HDR`.
    - STORE_MEM_ACK: go to `WR_DONE`.
    - LOAD_MEM_ACK: latch the header `msg_len` as `rsp_len`, clear `flit_cnt`, go to `RD_PAYLOAD`. If `rsp_len`==0, go to `IDLE` instead.
- `RD_PAYLOAD`
  - Pass-through: `rd_data_val`=`noc0_client_val`, `rd_data`=`noc0_client_data`, `client_noc0_rdy`=`rd_data_rdy`.
  - `rd_data_last`=(`flit_cnt`==`rsp_len`-1).
  - A transfer with last set goes to `IDLE`.
- `WR_DONE`: `wr_done_val`=1; on `wr_done_rdy`, go to `IDLE`.
- `resp_err` is cleared only by `rst`.

## Timing
- Reset: state `IDLE`, counters 0, `resp_err` 0.
  - Data outputs 0.
  - Every val/rdy output is 0, except `req_rdy`=1 in `IDLE`.
- Command accepted in cycle N: header valid in cycle N+1. The header is combinational from registers.
- Payload paths add zero latency. Data and val are combinational from the source; rdy is combinational from the sink.
- Back-to-back: a new command can be accepted in the cycle after the `IDLE` transition. `req_rdy` is 0 in every non-`IDLE` state.
- Valid is held until ready in every state; no output drops val while waiting for rdy.
- `flit_cnt` is `MSG_LENGTH_WIDTH` wide. The maximum `flits` fits; wrap never occurs.
- `rst` asserted mid-transaction returns to `IDLE` the next cycle. Any partial message is abandoned; the NoC is reset together with this block.

## Structure
- The shared package (`noc_defs`/`packet_defs`) holds:
  - `noc_hdr_flit`.
  - The MSG_TYPE constants, with no new constants added.
  - A new `ceil_flits(size)` function, shared with the controller's response-length logic.
- The state enum stays local.
- Sub-module `noc_dram_hdr_gen`: combinational header packing from the registered request and the params.

## Test plan
Examples use `NOC_DATA_BYTES`=64, `DRAM_X`=1, `DRAM_Y`=0.
- Store: `addr`=0x1000, `size`=128 → header `msg_len`=2, `data_size`=128, STORE_MEM. Two payload flits pass through unchanged. An inbound STORE_MEM_ACK gives one `wr_done_val` cycle.
- Load: `addr`=0x2040, `size`=100 → header `msg_len`=0, LOAD_MEM. A response header with `msg_len`=2 plus 2 flits gives 2 `rd_data` beats, with `rd_data_last` on beat 2.
- Backpressure: toggle `noc0_client_rdy` and `rd_data_rdy` randomly at 50% → no flit lost or duplicated, and val/data are stable while stalled.
- Wrong ACK: a load receives STORE_MEM_ACK → `resp_err`=1 sticky, the FSM stays in `RESP_HDR`, then a correct LOAD_MEM_ACK completes normally.
- Zero size: a store with `size`=0 → no NoC flit, `wr_done_val` 1 cycle after accept. A load with `size`=0 → `req_rdy` is back high the next cycle.
- Reset during `WR_PAYLOAD` after 1 of 4 flits → next cycle `IDLE`, all val outputs 0, and a new command is accepted normally.
